// File: rtl/delay_pkg.sv
// ============================================================================
// Module  : delay_pkg
// Brief   : Shared state encoding and address helpers for the multi-tap delay line.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int TAP_IDX_MIN_W = 1;

    // A single tap still needs a one-bit index register.
    function automatic int tap_idx_width(input int ntaps);
        return ($clog2(ntaps) < TAP_IDX_MIN_W) ? TAP_IDX_MIN_W : $clog2(ntaps);
    endfunction

    function automatic int unsigned wrap_sub(input int unsigned wp0,
                                             input int unsigned d,
                                             input int unsigned depth);
        return (wp0 >= d) ? (wp0 - d) : (wp0 + depth - d);
    endfunction

endpackage

`default_nettype wire

// File: rtl/delay_line_multitap_if.sv
// ============================================================================
// Module  : delay_line_multitap_if
// Brief   : Sample-in / tap-set-out bundle of the multi-tap delay line.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface delay_line_multitap_if #(
    parameter int DW    = 32,
    parameter int AW    = 15,
    parameter int NTAPS = 4
) ();
    logic                in_valid;
    logic [DW-1:0]       in_data;
    logic [NTAPS*AW-1:0] tap_delay;
    logic                clr_ovr;
    logic                busy;
    logic                out_valid;
    logic [NTAPS*DW-1:0] out_data;
    logic [AW-1:0]       wptr;
    logic                filled;
    logic                overrun;

    modport slave (
        input  in_valid, in_data, tap_delay, clr_ovr,
        output busy, out_valid, out_data, wptr, filled, overrun
    );

    modport master (
        output in_valid, in_data, tap_delay, clr_ovr,
        input  busy, out_valid, out_data, wptr, filled, overrun
    );
endinterface

`default_nettype wire

// File: rtl/delay_ram.sv
// ============================================================================
// Module  : delay_ram
// Brief   : Simple dual-port sample RAM, one write port, one registered read port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module delay_ram #(
    parameter int DW    = 32,
    parameter int AW    = 15,
    parameter int DEPTH = 20000
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);
    // Addresses never reach DEPTH, so only the bits the array needs are used.
    localparam int RAW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[RAW-1:0]] <= wdata;
        end
        rdata <= mem[raddr[RAW-1:0]];
    end
endmodule

`default_nettype wire

// File: rtl/delay_line_multitap.sv
// ============================================================================
// Module  : delay_line_multitap
// Brief   : Circular delay buffer with NTAPS time-multiplexed read taps.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module delay_line_multitap
    import delay_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 15,
    parameter int DEPTH = 20000,
    parameter int NTAPS = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    delay_line_multitap_if.slave  bus
);
    localparam int              TIW         = tap_idx_width(NTAPS);
    localparam logic [AW-1:0]   C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [TIW-1:0]  C_LAST_TAP  = TIW'(NTAPS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TIW-1:0]      r_tap_idx;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_wp0;
    logic [AW-1:0]       r_dly [NTAPS];
    logic                r_filled;
    logic                r_overrun;
    logic                r_rd_vld;
    logic [TIW-1:0]      r_rd_idx;
    logic                r_rd_mask;
    logic [DW-1:0]       r_stage [NTAPS];
    logic [NTAPS*DW-1:0] r_out_data;
    logic                r_out_valid;

    logic                w_accept;
    logic [AW-1:0]       w_d;
    logic [AW-1:0]       w_raddr;
    logic                w_mask;
    logic [DW-1:0]       w_rdata;
    logic [DW-1:0]       w_ret;
    logic [NTAPS*DW-1:0] w_final;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_d      = (r_dly[r_tap_idx] > C_LAST_ADDR) ? C_LAST_ADDR : r_dly[r_tap_idx];
    assign w_raddr  = AW'(wrap_sub(32'(r_wp0), 32'(w_d), 32'(DEPTH)));
    // Before the first wrap, anything older than the write pointer was never written.
    assign w_mask   = !r_filled && (w_d > r_wp0);
    assign w_ret    = r_rd_mask ? '0 : w_rdata;

    delay_ram #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_accept),
        .waddr (r_wptr),
        .wdata (bus.in_data),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = READ;
            READ:    if (r_tap_idx == C_LAST_TAP) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The last tap's data arrives during DRAIN and bypasses the staging register.
    always_comb begin
        w_final = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_final[k*DW +: DW] = (r_rd_vld && (r_rd_idx == TIW'(k))) ? w_ret : r_stage[k];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wp0 <= r_wptr;
            for (int k = 0; k < NTAPS; k++) begin
                r_dly[k] <= bus.tap_delay[k*AW +: AW];
            end
        end
        if (r_rd_vld) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (r_rd_idx == TIW'(k)) begin
                    r_stage[k] <= w_ret;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap_idx   <= '0;
            r_wptr      <= '0;
            r_filled    <= 1'b0;
            r_overrun   <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_idx    <= '0;
            r_rd_mask   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_rd_vld    <= (r_state == READ);
            r_rd_idx    <= r_tap_idx;
            r_rd_mask   <= w_mask;

            if (w_accept) begin
                r_tap_idx <= '0;
            end else if (r_state == READ) begin
                r_tap_idx <= (r_tap_idx == C_LAST_TAP) ? '0 : r_tap_idx + TIW'(1);
            end

            if (r_state == DRAIN) begin
                r_out_data  <= w_final;
                r_out_valid <= 1'b1;
                if (r_wptr == C_LAST_ADDR) begin
                    r_wptr   <= '0;
                    r_filled <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + AW'(1);
                end
            end

            if (bus.in_valid && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.wptr      = r_wptr;
    assign bus.filled    = r_filled;
    assign bus.overrun   = r_overrun;
endmodule

`default_nettype wire
